md_sequencer: RTL and testbench
===============================

// Module: md_sequencer
// PURPOSE
//  Iterative RV32M multiply/divide unit and its control FSM, next to the main ALU in EX.
//  Decode sends M-extension ops here when funct7 = 7'b0000001, instead of through ALUcntrl.
//  Holds one operation at a time; busy is the stall request to the hazard unit.
//  Shift-add multiply, restoring divide, 1 bit per cycle, one result-sign fix-up cycle.
// PARAMETERS
//  XLEN   32   operand/result width; must be even and >= 4
//  CNT_W  6    iteration counter width; must satisfy 2**CNT_W > XLEN
// PORTS
//  clk      in   1     rising-edge clock
//  rst      in   1     asynchronous, active-high reset
//  start    in   1     launch request; sampled only in IDLE or DONE
//  funct3   in   3     M op: 000 MUL 001 MULH 010 MULHSU 011 MULHU 100 DIV 101 DIVU 110 REM 111 REMU
//  op_a     in   XLEN  rs1 value, captured on the accepting edge
//  op_b     in   XLEN  rs2 value, captured on the accepting edge
//  flush    in   1     synchronous abort (branch mispredict / trap)
//  busy     out  1     1 in CALC and SIGN
//  done     out  1     1 for exactly one cycle, in state DONE
//  result   out  XLEN  final result; held from DONE until the next accepted start
// BEHAVIOUR
//  Reset (async): state=IDLE, busy=0, done=0, result=0, counter=0, internal regs=0.
//  FSM states IDLE, CALC, SIGN, DONE.
//   - IDLE -> CALC: start=1 and no special case.
//   - IDLE -> DONE: start=1 and special case (below).
//   - CALC -> SIGN: after XLEN iterations (counter reaches XLEN-1).
//   - SIGN -> DONE: always.
//   - DONE -> IDLE: start=0.
//   - DONE -> CALC/DONE: start=1, back-to-back launch with the same rules as IDLE.
//  start in CALC or SIGN: ignored. No queueing. Operands are not re-sampled.
//  Accepting edge:
//   - capture funct3.
//   - capture |op_a| and |op_b| for signed operands.
//     Signed: DIV, REM, MULH both; MULHSU op_a only.
//   - record the result sign:
//     MUL*/DIV sign = sa^sb; REM sign = sa (dividend sign).
//   - clear counter.
//  Multiply, per CALC cycle:
//   - if multiplier LSB is 1, add the multiplicand into the upper half of the 2*XLEN product register.
//   - shift right one bit.
//  Divide, per CALC cycle (restoring):
//   - shift {rem,quot} left one bit.
//   - trial = rem - divisor; if trial >= 0, rem = trial and quot LSB = 1.
//  Arithmetic rules:
//   - all adds are XLEN+1 bits wide.
//   - the product register is 2*XLEN bits; no truncation before SIGN.
//  SIGN cycle:
//   - two's-complement negate the full product (or quot/rem) if the recorded sign is 1.
//   - select MUL = prod[XLEN-1:0]; MULH/MULHSU/MULHU = prod[2XLEN-1:XLEN]; DIV* = quot; REM* = rem.
//   - register into result.
//  Special cases, resolved on the accepting edge (no CALC):
//   - divide by zero, op_b = 0: DIV/DIVU = all ones; REM/REMU = op_a.
//   - signed overflow, DIV op_a = 1<<(XLEN-1) and op_b = all ones: DIV = op_a; REM = 0.
//   - MUL* by zero is NOT special; it runs the full sequence.
//  Latency, edges from the accepting edge to done=1: XLEN+2 normal; 1 special.
//  busy is 0 in IDLE and DONE. The pipeline stalls on (busy | (start & ~done)) externally.
//  flush=1: next state IDLE from any state, done=0, result unchanged.
//   - flush has priority over start and over the CALC/SIGN transitions.
//  Reset mid-operation: immediate return to IDLE; no done pulse.
// TESTING
//  MUL op_a=7 op_b=-3 -> done at edge 34; result=0xFFFFFFEB; busy=1 for 33 cycles.
//  MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF^2 -> 0xFFFFFFFE; MULHSU -1 x 2 -> 0xFFFFFFFF.
//  DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
//  DIV 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000, REM -> 0; all with done 1 edge after start.
//  start held during CALC with new operands -> ignored, first result unchanged; start in DONE -> back-to-back, busy next cycle.
//  flush at CALC cycle 10, and async rst at cycle 20 of another op -> IDLE, done never pulses, result keeps the old value (rst: 0).

Source files
------------

// File: rtl/md_sequencer.sv
// md_sequencer: iterative RV32M multiply/divide unit with its control FSM
module md_sequencer #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);
   typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;
   localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};
   state_t            state, state_nx;
   logic [2:0]        f3;
   logic [XLEN-1:0]   mc;
   logic [2*XLEN-1:0] prod;
   logic              sg;
   logic [CNT_W-1:0]  cnt;
   logic              accept, special, div0, ovf, sa, sb;
   logic [XLEN-1:0]   ua, ub, spec_res, qn, rn, fin;
   logic [2*XLEN-1:0] pn, shl, step;
   logic [XLEN:0]     sum, trial;

   // operand magnitudes, special-case detection, one iteration step and sign fix-up
   always_comb begin
      sa       = (funct3 == 3'b001 || funct3 == 3'b010 || (funct3[2] && !funct3[0])) && op_a[XLEN-1];
      sb       = (funct3 == 3'b001 || (funct3[2] && !funct3[0])) && op_b[XLEN-1];
      ua       = sa ? -op_a : op_a;
      ub       = sb ? -op_b : op_b;
      div0     = funct3[2] && op_b == '0;
      ovf      = funct3[2] && !funct3[0] && op_a == MINV && op_b == '1;
      special  = div0 || ovf;
      spec_res = div0 ? (funct3[1] ? op_a : '1) : (funct3[1] ? '0 : op_a);
      sum      = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mc} : '0);
      shl      = {prod[2*XLEN-2:0], 1'b0};
      trial    = {1'b0, shl[2*XLEN-1:XLEN]} - {1'b0, mc};
      step     = f3[2] ? (trial[XLEN] ? shl : {trial[XLEN-1:0], shl[XLEN-1:1], 1'b1})
                       : {sum, prod[XLEN-1:1]};
      pn       = sg ? -prod : prod;
      qn       = sg ? -prod[XLEN-1:0] : prod[XLEN-1:0];
      rn       = sg ? -prod[2*XLEN-1:XLEN] : prod[2*XLEN-1:XLEN];
      fin      = f3[2] ? (f3[1] ? rn : qn) : (f3[1:0] == 2'b00 ? pn[XLEN-1:0] : pn[2*XLEN-1:XLEN]);
   end

   // next state and status outputs; flush overrides everything
   always_comb begin
      accept   = !flush && start && (state == IDLE || state == DONE);
      state_nx = flush ? IDLE
               : accept ? (special ? DONE : CALC)
               : state == CALC ? (cnt == CNT_W'(XLEN-1) ? SIGN : CALC)
               : state == SIGN ? DONE : IDLE;
      busy     = state == CALC || state == SIGN;
      done     = state == DONE;
   end

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // operand capture, iteration datapath and result register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         f3     <= '0;
         mc     <= '0;
         prod   <= '0;
         sg     <= 1'b0;
         cnt    <= '0;
         result <= '0;
      end else if (accept) begin
         f3   <= funct3;
         mc   <= funct3[2] ? ub : ua;
         prod <= {{XLEN{1'b0}}, funct3[2] ? ua : ub};
         sg   <= (funct3[2] && funct3[1]) ? sa : sa ^ sb;
         cnt  <= '0;
         if (special) result <= spec_res;
      end else if (state == CALC && !flush) begin
         prod <= step;
         cnt  <= cnt + CNT_W'(1);
      end else if (state == SIGN && !flush) begin
         result <= fin;
      end
   end
endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer: self-checking bench for md_sequencer
module tb_md_sequencer;
   logic        clk = 1'b0, rst = 1'b1, start = 1'b0, flush = 1'b0;
   logic [2:0]  funct3 = '0;
   logic [31:0] op_a = '0, op_b = '0;
   logic        busy, done;
   logic [31:0] result;
   int          errors = 0, checks = 0;

   typedef struct {
      logic [2:0]  f;
      logic [31:0] a, b, r;
      int          lat;
   } vec_t;
   vec_t tbl[14];

   md_sequencer dut (.clk(clk), .rst(rst), .start(start), .funct3(funct3), .op_a(op_a),
                     .op_b(op_b), .flush(flush), .busy(busy), .done(done), .result(result));

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      longint      sa = longint'($signed(a));
      longint      sb = longint'($signed(b));
      longint      ubl = longint'({32'b0, b});
      logic [63:0] p;
      case (f)
         3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ubl; return p[63:32]; end
         3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hffffffff;
            if (a == 32'h80000000 && b == 32'hffffffff) return a;
            p = sa / sb; return p[31:0];
         end
         3'd5: return b == 0 ? 32'hffffffff : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h80000000 && b == 32'hffffffff) return 0;
            p = sa % sb; return p[31:0];
         end
         default: return b == 0 ? a : a % b;
      endcase
   endfunction

   function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      return (f[2] && (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hffffffff))) ? 1 : 34;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'hffffffff;
         2: return 32'h80000000;
         3: return 32'(int'($urandom_range(0, 20)));
         default: return $urandom;
      endcase
   endfunction

   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   // entered and left #1 after a rising edge
   task automatic run_op(input string n, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input int el);
      int lat, bc;
      start = 1'b1; funct3 = f; op_a = a; op_b = b;
      @(posedge clk); #1;
      start = 1'b0; op_a = $urandom; op_b = $urandom; funct3 = 3'($urandom);
      lat = 1; bc = 0;
      while (!done && lat < 200) begin
         bc += int'(busy);
         @(posedge clk); #1;
         lat++;
      end
      chk({n, "_result"}, result, er);
      chk({n, "_latency"}, 32'(lat), 32'(el));
      chk({n, "_busy_cycles"}, 32'(bc), 32'(el - 1));
      @(posedge clk); #1;
      chk({n, "_done_one_cycle"}, {31'b0, done}, 32'd0);
   endtask

   initial begin
      int n, seen;
      logic [2:0]  f;
      logic [31:0] a, b;
      tbl[0]  = '{3'd0, 32'd7,         32'hfffffffd, 32'hffffffeb, 34};
      tbl[1]  = '{3'd1, 32'h80000000,  32'h80000000, 32'h40000000, 34};
      tbl[2]  = '{3'd3, 32'hffffffff,  32'hffffffff, 32'hfffffffe, 34};
      tbl[3]  = '{3'd2, 32'hffffffff,  32'd2,        32'hffffffff, 34};
      tbl[4]  = '{3'd4, 32'hfffffff9,  32'd2,        32'hfffffffd, 34};
      tbl[5]  = '{3'd6, 32'hfffffff9,  32'd2,        32'hffffffff, 34};
      tbl[6]  = '{3'd5, 32'd100,       32'd7,        32'd14,       34};
      tbl[7]  = '{3'd7, 32'd100,       32'd7,        32'd2,        34};
      tbl[8]  = '{3'd4, 32'd5,         32'd0,        32'hffffffff, 1};
      tbl[9]  = '{3'd7, 32'd5,         32'd0,        32'd5,        1};
      tbl[10] = '{3'd4, 32'h80000000,  32'hffffffff, 32'h80000000, 1};
      tbl[11] = '{3'd6, 32'h80000000,  32'hffffffff, 32'd0,        1};
      tbl[12] = '{3'd0, 32'h12345,     32'd0,        32'd0,        34};
      tbl[13] = '{3'd5, 32'h80000000,  32'hffffffff, 32'd0,        34};

      repeat (2) @(posedge clk);
      #1;
      chk("reset_busy", {31'b0, busy}, 32'd0);
      chk("reset_done", {31'b0, done}, 32'd0);
      chk("reset_result", result, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 14; i++)
         run_op($sformatf("vec%0d", i), tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].r, tbl[i].lat);

      // start held through CALC with changing operands must be ignored
      start = 1'b1; funct3 = 3'd0; op_a = 32'd7; op_b = 32'hfffffffd;
      @(posedge clk); #1;
      funct3 = 3'd5; op_a = 32'd100; op_b = 32'd200;
      repeat (10) @(posedge clk);
      #1;
      chk("held_start_busy", {31'b0, busy}, 32'd1);
      start = 1'b0;
      wait_done(n);
      chk("held_start_done", {31'b0, done}, 32'd1);
      chk("held_start_result", result, 32'hffffffeb);

      // back-to-back launch straight from DONE
      start = 1'b1; funct3 = 3'd7; op_a = 32'd100; op_b = 32'd7;
      @(posedge clk); #1;
      start = 1'b0;
      chk("b2b_busy", {31'b0, busy}, 32'd1);
      chk("b2b_done_low", {31'b0, done}, 32'd0);
      wait_done(n);
      chk("b2b_done", {31'b0, done}, 32'd1);
      chk("b2b_result", result, 32'd2);
      @(posedge clk); #1;

      // flush at CALC cycle 10
      start = 1'b1; funct3 = 3'd0; op_a = 32'd3; op_b = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_busy", {31'b0, busy}, 32'd0);
      seen = 0;
      repeat (40) begin
         seen |= int'(done);
         @(posedge clk); #1;
      end
      chk("flush_no_done", 32'(seen), 32'd0);
      chk("flush_result_kept", result, 32'd2);

      // asynchronous reset at cycle 20 of a divide
      start = 1'b1; funct3 = 3'd4; op_a = 32'd1000; op_b = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (19) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_result", result, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 0;
      repeat (40) begin
         seen |= int'(done);
         @(posedge clk); #1;
      end
      chk("rst_no_done", 32'(seen), 32'd0);
      chk("rst_result_kept", result, 32'd0);

      for (int i = 0; i < 40; i++) begin
         f = 3'($urandom);
         a = pick();
         b = pick();
         run_op($sformatf("rnd%0d_f%0d", i, f), f, a, b, model(f, a, b), model_lat(f, a, b));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
